// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the E-stage multiply/divide unit:
//   - md_op encodings (MD_NONE .. MD_MADD)
//   - mf_sel read-select encodings
//   - default mult/div latencies
//   - helpers that classify an md_op as a multi-cycle operation
// Optional feature macro: MD_MADD_EN (op 7 = madd when defined, no-op otherwise).
// ---------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MTHI  = 3'd1,
    MD_MTLO  = 3'd2,
    MD_MULT  = 3'd3,
    MD_MULTU = 3'd4,
    MD_DIV   = 3'd5,
    MD_DIVU  = 3'd6,
    MD_MADD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MF_NONE = 2'b00,
    MF_HI   = 2'b01,
    MF_LO   = 2'b10,
    MF_BOTH = 2'b11
  } mf_sel_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Operations that use the multiplier latency.
  function automatic logic md_is_mul(input logic [2:0] op);
    case (op)
      MD_MULT, MD_MULTU: return 1'b1;
`ifdef MD_MADD_EN
      MD_MADD:           return 1'b1;
`endif
      default:           return 1'b0;
    endcase
  endfunction

  // Operations that occupy the unit for several cycles (set busy).
  function automatic logic md_is_long(input logic [2:0] op);
    case (op)
      MD_DIV, MD_DIVU: return 1'b1;
      default:         return md_is_mul(op);
    endcase
  endfunction

endpackage

// File: rtl/md_result_calc.sv
// ---------------------------------------------------------------------------
// md_result_calc
// Combinational result of mult/multu/div/divu (and madd when MD_MADD_EN is
// defined) from the operation, both operands and the current HI/LO.
// Ports:
//   i_op       : md_op encoding
//   i_rs, i_rt : operands (rs is the dividend / multiplicand)
//   i_hi, i_lo : current HI/LO (accumulator base for madd)
//   o_res_hi   : HI result (product high half / remainder)
//   o_res_lo   : LO result (product low half / quotient)
//   o_div_zero : divide op with rt == 0; result must not be committed
// Optional feature macro: MD_MADD_EN.
// ---------------------------------------------------------------------------
module md_result_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_res_hi,
  output logic [WIDTH-1:0] o_res_lo,
  output logic             o_div_zero
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] w_rs_sx;
  logic signed [2*WIDTH-1:0] w_rt_sx;
  logic signed [2*WIDTH-1:0] w_sprod;
  logic        [2*WIDTH-1:0] w_uprod;

  logic                      w_rt_zero;
  logic                      w_sovf;
  logic signed [WIDTH-1:0]   w_sdivd;
  logic signed [WIDTH-1:0]   w_sdivs;
  logic signed [WIDTH-1:0]   w_squot;
  logic signed [WIDTH-1:0]   w_srem;
  logic        [WIDTH-1:0]   w_udivs;
  logic        [WIDTH-1:0]   w_uquot;
  logic        [WIDTH-1:0]   w_urem;

  assign w_rs_sx = {{WIDTH{i_rs[WIDTH-1]}}, i_rs};
  assign w_rt_sx = {{WIDTH{i_rt[WIDTH-1]}}, i_rt};
  assign w_sprod = w_rs_sx * w_rt_sx;
  assign w_uprod = {{WIDTH{1'b0}}, i_rs} * {{WIDTH{1'b0}}, i_rt};

  assign w_rt_zero = (i_rt == '0);
  assign w_sovf    = (i_rs == SMIN) && (&i_rt);

  // A zero divisor is replaced by 1 so the divider never sees it; the result
  // is dropped anyway. MIN / -1 is computed as MIN / 1, which yields exactly
  // the required LO = MIN, HI = 0 without a separate override path.
  assign w_sdivd = i_rs;
  assign w_sdivs = (w_rt_zero || w_sovf) ? ONE : i_rt;
  assign w_squot = w_sdivd / w_sdivs;
  assign w_srem  = w_sdivd % w_sdivs;

  assign w_udivs = w_rt_zero ? ONE : i_rt;
  assign w_uquot = i_rs / w_udivs;
  assign w_urem  = i_rs % w_udivs;

`ifdef MD_MADD_EN
  logic [2*WIDTH-1:0] w_acc;
  assign w_acc = {i_hi, i_lo} + $unsigned(w_sprod);
`endif

  always_comb begin
    o_res_hi   = i_hi;
    o_res_lo   = i_lo;
    o_div_zero = 1'b0;
    case (i_op)
      MD_MULT:  {o_res_hi, o_res_lo} = $unsigned(w_sprod);
      MD_MULTU: {o_res_hi, o_res_lo} = w_uprod;
      MD_DIV: begin
        o_res_lo   = $unsigned(w_squot);
        o_res_hi   = $unsigned(w_srem);
        o_div_zero = w_rt_zero;
      end
      MD_DIVU: begin
        o_res_lo   = w_uquot;
        o_res_hi   = w_urem;
        o_div_zero = w_rt_zero;
      end
`ifdef MD_MADD_EN
      MD_MADD:  {o_res_hi, o_res_lo} = w_acc;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_param.sv
// ---------------------------------------------------------------------------
// md_unit_param
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a
// down-counter, and raises the D-stage stall for md-class instructions.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   md_op     : 0 none, 1 mthi, 2 mtlo, 3 mult, 4 multu, 5 div, 6 divu, 7 madd
//   md_start  : E-stage instruction valid (md_op ignored when low)
//   rs_val    : forwarded rs operand
//   rt_val    : forwarded rt operand
//   mf_sel    : 01 read HI, 10 read LO, otherwise 0
//   d_is_md   : D-stage instruction is md-class
//   md_rdata  : combinational HI/LO read
//   busy      : operation in flight (registered)
//   md_stall  : stall request to D/F
//   hi, lo    : HI/LO registers
// Optional feature macro: MD_MADD_EN (op 7 = madd; otherwise op 7 is a no-op).
// ---------------------------------------------------------------------------
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [1:0]       mf_sel,
  input  logic             d_is_md,
  output logic [WIDTH-1:0] md_rdata,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_div_zero;

  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_div_zero;
  logic             w_op_long;

  md_result_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .i_op       (md_op),
    .i_rs       (rs_val),
    .i_rt       (rt_val),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .o_res_hi   (w_res_hi),
    .o_res_lo   (w_res_lo),
    .o_div_zero (w_div_zero)
  );

  assign w_op_long = md_is_long(md_op);

  // r_busy mirrors (r_cnt != 0) as a register so the busy output has no
  // comparator in front of it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
      r_div_zero <= 1'b0;
    end else if (r_busy) begin
      // Any new request while busy is ignored; only the countdown runs.
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        if (!r_div_zero) begin
          r_hi <= r_res_hi;
          r_lo <= r_res_lo;
        end
      end
    end else if (md_start) begin
      case (md_op)
        MD_MTHI: r_hi <= rs_val;
        MD_MTLO: r_lo <= rs_val;
        default: begin
          if (w_op_long) begin
            r_res_hi   <= w_res_hi;
            r_res_lo   <= w_res_lo;
            r_div_zero <= w_div_zero;
            r_busy     <= 1'b1;
            r_cnt      <= md_is_mul(md_op) ? CNT_W'(MULT_CYCLES)
                                           : CNT_W'(DIV_CYCLES);
          end
        end
      endcase
    end
  end

  always_comb begin
    md_rdata = '0;
    case (mf_sel)
      MF_HI:   md_rdata = r_hi;
      MF_LO:   md_rdata = r_lo;
      default: md_rdata = '0;
    endcase
  end

  // The start term covers the cycle in which the op sits in E but busy has
  // not yet risen.
  assign md_stall = d_is_md & (r_busy | (md_start & w_op_long));

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit_param.sv
// ---------------------------------------------------------------------------
// tb_md_unit_param
// Scoreboard bench for md_unit_param (default parameters). The stimulus
// process computes each operation's final HI/LO and latency with plain
// 64-bit arithmetic and queues it; a monitor tracks accepted operations,
// expected busy timing and HI/LO, and compares every cycle.
// ---------------------------------------------------------------------------
module tb_md_unit_param;

  localparam int MC = 5;
  localparam int DC = 10;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic        md_start = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [1:0]  mf_sel = 2'b00;
  logic        d_is_md = 1'b0;
  logic [31:0] md_rdata;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit_param #(
    .WIDTH       (32),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .md_start (md_start),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .mf_sel   (mf_sel),
    .d_is_md  (d_is_md),
    .md_rdata (md_rdata),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } item_t;

  item_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // stimulus-side architectural state (values after each issued op)
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // monitor state
  int          rem = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;
  item_t       pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic is_long(input logic [2:0] op);
`ifdef MD_MADD_EN
    return (op >= 3'd3);
`else
    return (op >= 3'd3) && (op <= 3'd6);
`endif
  endfunction

  // Reference: final HI/LO and busy length of one op from the rules.
  function automatic item_t model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] h,
                                  input logic [31:0] l);
    item_t       it;
    longint      sa, sb, qv, rv;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    it.hi = h;
    it.lo = l;
    it.cycles = 0;
    case (op)
      3'd1: it.hi = a;
      3'd2: it.lo = a;
      3'd3: begin p = sa * sb; {it.hi, it.lo} = p; it.cycles = MC; end
      3'd4: begin p = {32'd0, a} * {32'd0, b}; {it.hi, it.lo} = p; it.cycles = MC; end
      3'd5: begin
        it.cycles = DC;
        if (b != 0) begin
          qv = sa / sb;
          rv = sa % sb;
          it.lo = qv[31:0];
          it.hi = rv[31:0];
        end
      end
      3'd6: begin
        it.cycles = DC;
        if (b != 0) begin
          it.lo = a / b;
          it.hi = a % b;
        end
      end
`ifdef MD_MADD_EN
      3'd7: begin p = {h, l} + 64'(sa * sb); {it.hi, it.lo} = p; it.cycles = MC; end
`endif
      default: ;
    endcase
    return it;
  endfunction

  task automatic set_dmd(input int dmd);
    if (dmd == 2) d_is_md = 1'($urandom_range(0, 1));
    else          d_is_md = (dmd != 0);
    mf_sel = 2'($urandom_range(0, 3));
  endtask

  // Called at posedge+2 with the unit idle; returns at posedge+2 with it idle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int dmd);
    item_t it;
    it = model(op, a, b, m_hi, m_lo);
    if (op != 3'd0) begin
      sb_q.push_back(it);
      m_hi = it.hi;
      m_lo = it.lo;
    end
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    md_start = 1'b1;
    set_dmd(dmd);
    @(posedge clk); #2;
    md_start = 1'b0;
    md_op    = 3'($urandom_range(0, 7));
    for (int i = 0; i < it.cycles; i++) begin
      set_dmd(dmd);
      @(posedge clk); #2;
    end
  endtask

  // Monitor: acceptance and countdown at the active edge.
  always @(posedge clk) begin
    item_t it;
    if (!reset) begin
      rem = 0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        cur_hi = pend.hi;
        cur_lo = pend.lo;
      end
    end else if (md_start && md_op != 3'd0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept at %0t: op %0d with nothing queued", $time, md_op);
      end else begin
        it = sb_q.pop_front();
        if (it.cycles == 0) begin
          cur_hi = it.hi;
          cur_lo = it.lo;
        end else begin
          rem  = it.cycles;
          pend = it;
        end
      end
    end
  end

  always @(negedge reset) begin
    rem    = 0;
    cur_hi = '0;
    cur_lo = '0;
    sb_q.delete();
    #1;
    chk_bit("rst_busy_now", busy, 1'b0);
    chk("rst_hi_now", hi, 32'h0);
    chk("rst_lo_now", lo, 32'h0);
  end

  // Monitor: compare outputs away from the active edge.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    if (!reset) begin
      chk_bit("rst_busy", busy, 1'b0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
    end else begin
      exp_rd = (mf_sel == 2'b01) ? cur_hi : (mf_sel == 2'b10) ? cur_lo : 32'h0;
      chk_bit("busy", busy, rem > 0);
      chk("hi", hi, cur_hi);
      chk("lo", lo, cur_lo);
      chk("md_rdata", md_rdata, exp_rd);
      chk_bit("md_stall", md_stall,
              d_is_md & ((rem > 0) | (md_start & is_long(md_op))));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    item_t       it;

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #2;

    // move-to writes
    issue(3'd1, 32'h1234_5678, 32'h0, 2);
    issue(3'd2, 32'h0000_0009, 32'h0, 2);

    // multiply signed / unsigned
    issue(3'd3, 32'hFFFF_FFFE, 32'd3, 2);
    issue(3'd4, 32'hFFFF_FFFE, 32'd3, 2);

    // divide, divide by zero, signed overflow
    issue(3'd5, 32'hFFFF_FFF9, 32'd2, 2);
    issue(3'd6, 32'd7, 32'd0, 2);
    issue(3'd5, SMIN, 32'hFFFF_FFFF, 2);
    issue(3'd6, SMIN, 32'hFFFF_FFFF, 2);

    // stall with d_is_md held high
    issue(3'd3, 32'd1234, 32'd5678, 1);
    d_is_md = 1'b1;
    @(posedge clk); #2;

    // second mult presented during busy is ignored
    it = model(3'd3, 32'd100, 32'hFFFF_FF00, m_hi, m_lo);
    sb_q.push_back(it);
    m_hi = it.hi;
    m_lo = it.lo;
    md_op = 3'd3; rs_val = 32'd100; rt_val = 32'hFFFF_FF00; md_start = 1'b1;
    @(posedge clk); #2;
    md_op = 3'd4; rs_val = 32'hDEAD_BEEF; rt_val = 32'h7; md_start = 1'b1;
    @(posedge clk); #2;
    md_start = 1'b0;
    for (int i = 0; i < MC - 1; i++) begin
      @(posedge clk); #2;
    end

    // md_op = 0 with start, and op with start low: no effect
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    md_op = 3'd5; rt_val = 32'd3; md_start = 1'b0;
    @(posedge clk); #2;

    // op 7: madd or no-op depending on build
    issue(3'd1, 32'h0, 32'h0, 2);
    issue(3'd2, 32'h5, 32'h0, 2);
    issue(3'd7, 32'd2, 32'd3, 1);

    // reset on busy cycle 2 of a div
    it = model(3'd5, 32'd1000, 32'd7, m_hi, m_lo);
    sb_q.push_back(it);
    md_op = 3'd5; rs_val = 32'd1000; rt_val = 32'd7; md_start = 1'b1;
    @(posedge clk); #2;
    md_start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: begin a = SMIN; b = 32'hFFFF_FFFF; end
        1: b = 32'h0;
        2: b = 32'($urandom_range(1, 9));
        3: a = -32'($urandom_range(0, 50));
        default: ;
      endcase
      issue(op, a, b, 2);
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d queued ops never accepted, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Successor to the fixed 3-bit MDop decode: owns the HI/LO registers, configurable mult/div latencies and a busy counter.
- Generates the D-stage stall for md-class instructions.
- Sits beside the ALU; its read mux result joins the E-stage result path selected by ismd.

Parameters:
WIDTH, 32, operand and HI/LO width.
MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
DIV_CYCLES, 10, busy cycles for div/divu (>=1).
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
md_op  in  3  0 none, 1 mthi, 2 mtlo, 3 mult, 4 multu, 5 div, 6 divu, 7 madd (optional).
md_start  in  1  E-stage instruction valid; md_op acted on only when high.
rs_val  in  WIDTH  forwarded rs operand.
rt_val  in  WIDTH  forwarded rt operand.
mf_sel  in  2  01 read HI, 10 read LO, else 0.
d_is_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo/madd.
md_rdata  out  WIDTH  combinational HI/LO read per mf_sel.
busy  out  1  operation in flight.
md_stall  out  1  stall request to D/F.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, reset low): HI=0, LO=0, counter=0, busy=0, latched results=0. An in-flight op is aborted and its result discarded.
- busy = (counter != 0), registered.
- md_stall = d_is_md & (busy | (md_start & md_op in {3,4,5,6,7})), combinational.
- mthi/mtlo with md_start and !busy: write rs_val into HI/LO at the next edge; no busy.
- mult/multu/div/divu/madd with md_start and !busy:
  - At the edge, compute the result into internal res_hi/res_lo.
  - Load counter with MULT_CYCLES (mult/multu/madd) or DIV_CYCLES (div/divu).
  - Each later edge decrements the counter.
  - On the edge where the counter goes 1->0, copy res_hi/res_lo to HI/LO and drop busy on that same edge.
  - busy is therefore high for exactly N cycles after the start edge; new HI/LO are readable in the first cycle busy is low.
- mult: signed {HI,LO} = rs*rt (2*WIDTH). multu: unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. divu: unsigned.
- Divide by zero: HI/LO are left unchanged at completion; busy timing is still applied.
- Signed overflow (MIN / -1): LO = MIN, HI = 0.
- md_start with any md_op while busy: ignored, no state change. The pipeline guarantees this cannot happen via md_stall.
- md_op=0 or md_start=0: no effect.
- md_rdata reflects HI/LO register contents (pre-write) even while busy. The stall prevents mfhi/mflo from reaching E while busy.

Optional Feature:
- MD_MADD_EN defined: op 7 = madd, {HI,LO} <= {HI,LO} + signed(rs*rt), mod 2^(2*WIDTH), with MULT_CYCLES latency. The accumulate uses the HI/LO values present at the start edge.
- MD_MADD_EN undefined: op 7 is a no-op, never sets busy, and is excluded from the md_stall start term.

Decomposition:
- Package md_pkg holds the MDop encodings (MD_NONE..MD_MADD), the mf_sel encodings, and the default latencies.
- One natural sub-module, md_result_calc: combinational mult/div/madd result from op, operands and current HI/LO.
- md_unit_param keeps the counter, registers and stall logic.

Test Plan:
- Reset, then mthi rs=0x12345678, next cycle mtlo rs=0x9 -> hi=0x12345678, lo=0x9, busy never high.
- mult rs=0xFFFFFFFE (-2), rt=3, MULT_CYCLES=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x2, lo=0xFFFFFFFA.
- div rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after DIV_CYCLES. divu rs=7, rt=0 -> hi/lo unchanged, busy still 10 cycles.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mult started, d_is_md=1 throughout -> md_stall high in the start cycle and all busy cycles, low after. A second mult presented while busy is ignored.
- Drive reset low on busy cycle 2 of a div -> hi=lo=0 and busy=0 immediately. With MD_MADD_EN: hi=0, lo=5, madd 2*3 -> lo=11.
